// File: rtl/scan_multiplexer.sv
// Registered CHANNELS-to-1 bus multiplexer with a valid/ready output.
// Direct mode emits one beat from addr; scan mode emits channels 0..CHANNELS-1 in order.
module scan_multiplexer #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          addr,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  output logic                      done
);

  localparam int SLOTS = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic              mode_reg, mode_next;
  logic [SEL_W-1:0]  ch_reg, ch_next;
  logic [WIDTH-1:0]  out_reg;
  logic [SEL_W-1:0]  chan_reg;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic              load;
  logic [SEL_W-1:0]  load_ch;

  // Every select code maps to a slot; codes past the last channel read as zero.
  logic [WIDTH-1:0]  chan_data [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < CHANNELS) begin : g_live
        assign chan_data[gi] = in[gi*WIDTH +: WIDTH];
      end else begin : g_empty
        assign chan_data[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      ch_reg    <= '0;
      out_reg   <= '0;
      chan_reg  <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      ch_reg    <= ch_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      if (load) begin
        out_reg  <= chan_data[load_ch];
        chan_reg <= load_ch;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    ch_next    = ch_reg;
    valid_next = valid_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    load_ch    = ch_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          load_ch    = mode ? '0 : addr;
          ch_next    = load_ch;
          load       = 1'b1;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!mode_reg || ch_reg == LAST_CH) begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            // Next scan beat is loaded on the accepting edge, so there is no bubble.
            load_ch = ch_reg + 1'b1;
            ch_next = load_ch;
            load    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out       = out_reg;
  assign out_chan  = chan_reg;
  assign out_valid = valid_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_scan_multiplexer.sv
// Bench for scan_multiplexer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based request model.
module tb_scan_multiplexer;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int SEL_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CH*WIDTH-1:0] in = '0;
  logic [SEL_W-1:0]  addr = '0;
  logic              mode = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out;
  logic [SEL_W-1:0]  out_chan;
  logic              out_valid;
  logic              done;

  // Three-channel instance for the out-of-range direct address case.
  logic [3*WIDTH-1:0] in3 = '0;
  logic [SEL_W-1:0]   addr3 = '0;
  logic               mode3 = 1'b0;
  logic               start3 = 1'b0;
  logic               ready3 = 1'b1;
  logic [WIDTH-1:0]   out3;
  logic [SEL_W-1:0]   chan3;
  logic               valid3;
  logic               done3;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  scan_multiplexer #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .addr(addr), .mode(mode), .start(start),
    .out_ready(out_ready), .out(out), .out_chan(out_chan), .out_valid(out_valid), .done(done)
  );

  scan_multiplexer #(.WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .addr(addr3), .mode(mode3), .start(start3),
    .out_ready(ready3), .out(out3), .out_chan(chan3), .out_valid(valid3), .done(done3)
  );

  // Reference model: a request becomes a list of channels still to send.
  int         rem[$];
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_out = '0;
  int         m_chan = 0;

  function automatic logic [7:0] sample(input int c);
    if (c < CH) return in[c*WIDTH +: WIDTH];
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem.delete();
      m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_chan = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (out_ready) begin
          if (rem.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_chan = rem.pop_front();
            m_out  = sample(m_chan);
          end
        end
      end else if (start) begin
        rem.delete();
        if (mode) for (int c = 0; c < CH; c++) rem.push_back(c);
        else rem.push_back(int'(addr));
        m_chan = rem.pop_front();
        m_out  = sample(m_chan);
        m_busy = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", 32'(out_valid), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_out", 32'(out), 32'(m_out));
      chk("model_chan", 32'(out_chan), 32'(m_chan));
    end
  end

  always @(negedge clk) begin
    if (chk_en && out_valid && out_ready)
      $display("beat chan=%0d data=%02h", out_chan, out);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] BASE = {8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    // Reset holds outputs at zero regardless of activity
    for (int i = 0; i < 3; i++) begin
      tick();
      in = $urandom; start = 1'($urandom); mode = 1'($urandom); addr = 2'($urandom);
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
    end
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out", 32'(out), 32'h0);
      chk("idle_valid", 32'(out_valid), 32'h0);
      chk("idle_chan", 32'(out_chan), 32'h0);
    end

    // Direct mode, every address
    in = BASE; out_ready = 1'b1; mode = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); start = 1'b1;
      tick();
      start = 1'b0;
      chk("dir_out", 32'(out), 32'(exp_b[a]));
      chk("dir_chan", 32'(out_chan), 32'(a));
      chk("dir_valid", 32'(out_valid), 32'h1);
      tick();
      chk("dir_valid_drop", 32'(out_valid), 32'h0);
      chk("dir_done", 32'(done), 32'h1);
      tick();
      chk("dir_done_pulse", 32'(done), 32'h0);
    end

    // Scan with ready high; start held through the scan adds nothing
    mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("scan_out", 32'(out), 32'(exp_b[i]));
      chk("scan_chan", 32'(out_chan), 32'(i));
      chk("scan_valid", 32'(out_valid), 32'h1);
    end
    start = 1'b0;
    tick();
    chk("scan_done", 32'(done), 32'h1);
    chk("scan_end_valid", 32'(out_valid), 32'h0);
    tick();
    chk("scan_no_extra", 32'(out_valid), 32'h0);

    // Scan with backpressure on channel 2 while its input changes
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("bp_beat2", 32'(out), 32'h33);
    out_ready = 1'b0; in[23:16] = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_out", 32'(out), 32'h33);
      chk("bp_hold_chan", 32'(out_chan), 32'h2);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next", 32'(out), 32'h44);
    tick();
    chk("bp_done", 32'(done), 32'h1);
    in = BASE;

    // Out-of-range direct address on the 3-channel instance
    in3 = 24'hA5C3E7; addr3 = 2'd3; mode3 = 1'b0; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("oor_out", 32'(out3), 32'h0);
    chk("oor_chan", 32'(chan3), 32'h3);
    chk("oor_valid", 32'(valid3), 32'h1);
    tick();
    chk("oor_valid_drop", 32'(valid3), 32'h0);
    chk("oor_done", 32'(done3), 32'h1);

    // Asynchronous reset mid-scan
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_beat1", 32'(out_chan), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(out_valid), 32'h0);
    chk("mid_async_out", 32'(out), 32'h0);
    tick();
    chk("mid_no_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_restart_chan", 32'(out_chan), 32'h0);
    chk("mid_restart_out", 32'(out), 32'h11);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick();
      in        = $urandom;
      addr      = 2'($urandom);
      mode      = 1'($urandom);
      start     = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(9) < 7);
      if ($urandom_range(149) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
